// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with single-cycle logic/arith/compare ops and
// iterative one-bit-per-cycle shifts behind valid/ready handshakes.
module alu_exec_unit #(
  parameter int XLEN    = 64,
  parameter int SHAMT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_illegal,
  output logic            busy
);
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1010;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state_q, state_d;
  logic [XLEN-1:0]      acc_q, acc_d, res_q, res_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]           op_q, op_d;
  logic                 zero_q, zero_d, ill_q, ill_d;
  logic [XLEN-1:0]      alu_res, step;
  logic                 alu_ill, is_shift, accept;
  logic [SHAMT_W-1:0]   shamt;

  assign shamt    = op_b[SHAMT_W-1:0];
  assign is_shift = (alu_ctrl == OP_SLL) | (alu_ctrl == OP_SRL) | (alu_ctrl == OP_SRA);
  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid & in_ready;

  // Shift ops report op_a here; that value is only consumed when shamt is 0.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_ctrl)
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_SLL, OP_SRL, OP_SRA: alu_res = op_a;
      default: alu_ill = 1'b1;
    endcase
  end

  assign step = (op_q == OP_SLL) ? {acc_q[XLEN-2:0], 1'b0}
                                 : {(op_q == OP_SRA) & acc_q[XLEN-1], acc_q[XLEN-1:1]};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE: if (accept) begin
        if (is_shift && shamt != '0) begin
          acc_d   = op_a;
          cnt_d   = shamt;
          op_d    = alu_ctrl;
          state_d = SHIFT;
        end else begin
          res_d   = alu_res;
          zero_d  = (alu_res == '0);
          ill_d   = alu_ill;
          state_d = DONE;
        end
      end
      SHIFT: begin
        acc_d = step;
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          res_d   = step;
          zero_d  = (step == '0);
          ill_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign out_result  = res_q;
  assign out_zero    = zero_q;
  assign out_illegal = ill_q;
endmodule
